// File: rtl/sum_ascii_framer.sv
// sum_ascii_framer: snapshots {a, b, sum} and streams the ASCII frame
// "AA+BB=SS\r\n" to uart_tx one byte at a time over its en/busy handshake.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   a, b, sum           operand latches and adder result (snapshotted at frame start)
//   send_req            frame request, level-sampled while idle
//   uart_tx_busy        transmitter busy
//   uart_tx_en          one-cycle byte-load strobe
//   uart_tx_data        ASCII byte presented to the transmitter
//   frame_busy          high while a frame is in progress
//   frame_done          one-cycle pulse after the last byte
//   tx_timeout          sticky byte-timeout flag, cleared at the next frame start
module sum_ascii_framer #(
  parameter bit          AUTO_SEND    = 1'b0,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [4:0] sum,
  input  logic       send_req,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       tx_timeout
);

  localparam int unsigned CntW    = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned IdxW    = 4;
  localparam int unsigned LastIdx = 9;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        snap_a_q, snap_a_d;
  logic [3:0]        snap_b_q, snap_b_d;
  logic [4:0]        snap_s_q, snap_s_d;
  logic              sent_valid_q, sent_valid_d;
  logic              en_q, en_d;
  logic [7:0]        data_q, data_d;
  logic              fbusy_q, fbusy_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              start_c;
  logic [7:0]        char_c;

  // Tens digit by comparison ladder; values 0..31 only.
  function automatic logic [1:0] tens_of(input logic [4:0] v);
    logic [1:0] t;
    if (v >= 5'd30)      t = 2'd3;
    else if (v >= 5'd20) t = 2'd2;
    else if (v >= 5'd10) t = 2'd1;
    else                 t = 2'd0;
    return t;
  endfunction

  function automatic logic [7:0] hi_char(input logic [4:0] v);
    return 8'h30 + 8'(tens_of(v));
  endfunction

  // ones = v - 10*tens, with 10*t built as 8t + 2t.
  function automatic logic [7:0] lo_char(input logic [4:0] v);
    logic [1:0] t;
    logic [4:0] o;
    t = tens_of(v);
    o = v - ({t, 3'b000} + 5'({t, 1'b0}));
    return 8'h30 + 8'(o);
  endfunction

  // Character of the current frame position, taken from the snapshot.
  always_comb begin
    char_c = 8'h00;
    case (idx_q)
      4'd0:    char_c = hi_char({1'b0, snap_a_q});
      4'd1:    char_c = lo_char({1'b0, snap_a_q});
      4'd2:    char_c = 8'h2B;
      4'd3:    char_c = hi_char({1'b0, snap_b_q});
      4'd4:    char_c = lo_char({1'b0, snap_b_q});
      4'd5:    char_c = 8'h3D;
      4'd6:    char_c = hi_char(snap_s_q);
      4'd7:    char_c = lo_char(snap_s_q);
      4'd8:    char_c = 8'h0D;
      4'd9:    char_c = 8'h0A;
      default: char_c = 8'h00;
    endcase
  end

  assign start_c = send_req ||
                   (AUTO_SEND && (!sent_valid_q || ({a, b} != {snap_a_q, snap_b_q})));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    snap_s_d     = snap_s_q;
    sent_valid_d = sent_valid_q;
    en_d         = 1'b0;
    data_d       = data_q;
    fbusy_d      = fbusy_q;
    done_d       = 1'b0;
    tmo_d        = tmo_q;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          snap_a_d = a;
          snap_b_d = b;
          snap_s_d = sum;
          idx_d    = '0;
          fbusy_d  = 1'b1;
          tmo_d    = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        data_d = char_c;
        if (!uart_tx_busy) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (uart_tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: count the byte as sent.
          tmo_d   = 1'b1;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_LO: begin
        if (!uart_tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q != IdxW'(LastIdx)) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = SEND;
        end else begin
          idx_d        = '0;
          done_d       = 1'b1;
          fbusy_d      = 1'b0;
          sent_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      snap_s_q     <= '0;
      sent_valid_q <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      fbusy_q      <= 1'b0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      snap_s_q     <= snap_s_d;
      sent_valid_q <= sent_valid_d;
      en_q         <= en_d;
      data_q       <= data_d;
      fbusy_q      <= fbusy_d;
      done_q       <= done_d;
      tmo_q        <= tmo_d;
    end
  end

  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign frame_busy   = fbusy_q;
  assign frame_done   = done_q;
  assign tx_timeout   = tmo_q;

endmodule
